// File: rtl/seg7_scan_reader.sv
// Receive side of a multiplexed active-low 7-segment bus: waits for each digit to settle,
// decodes the glyph back to hex, and publishes one word per complete scan.
module seg7_scan_reader #(
    parameter int NDIG   = 4,
    parameter int SETTLE = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [7:0]        seg_in,
    input  logic [NDIG-1:0]   an_in,
    output logic [4*NDIG-1:0] word_out,
    output logic [NDIG-1:0]   dp_out,
    output logic              word_valid,
    output logic              pat_err
);
    localparam int            CW       = $clog2(SETTLE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] CNT_SAT  = CW'(SETTLE);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;

    logic [7:0]        seg_meta_reg, seg_sync_reg, seg_prev_reg;
    logic [NDIG-1:0]   an_meta_reg, an_sync_reg, an_prev_reg;
    state_t            state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic [NDIG-1:0]   seen_reg, seen_next;
    logic              bad_reg, bad_next;
    logic [4*NDIG-1:0] shadow_reg, shadow_next;
    logic [NDIG-1:0]   shadow_dp_reg, shadow_dp_next;
    logic [4*NDIG-1:0] word_reg;
    logic [NDIG-1:0]   dp_reg;
    logic              word_valid_reg, pat_err_reg;

    logic [NDIG-1:0]   lit;
    logic [NDIG-1:0]   slot_wr;
    logic              one_cold, changed, sample, complete;
    logic              glyph_ok;
    logic [3:0]        glyph_nib;

    // lit is one-hot exactly when a single digit is selected, so it doubles as the slot mask
    assign lit      = ~an_sync_reg;
    assign one_cold = (lit != '0) && ((lit & (lit - NDIG'(1))) == '0);
    assign changed  = (seg_sync_reg != seg_prev_reg) || (an_sync_reg != an_prev_reg);
    assign complete = &seen_reg;

    always_comb begin
        glyph_ok  = 1'b1;
        glyph_nib = 4'h0;
        case (seg_sync_reg[6:0])
            7'h40:   glyph_nib = 4'h0;
            7'h79:   glyph_nib = 4'h1;
            7'h24:   glyph_nib = 4'h2;
            7'h30:   glyph_nib = 4'h3;
            7'h19:   glyph_nib = 4'h4;
            7'h12:   glyph_nib = 4'h5;
            7'h02:   glyph_nib = 4'h6;
            7'h78:   glyph_nib = 4'h7;
            7'h00:   glyph_nib = 4'h8;
            7'h10:   glyph_nib = 4'h9;
            7'h08:   glyph_nib = 4'hA;
            7'h03:   glyph_nib = 4'hB;
            7'h46:   glyph_nib = 4'hC;
            7'h21:   glyph_nib = 4'hD;
            7'h06:   glyph_nib = 4'hE;
            7'h0E:   glyph_nib = 4'hF;
            default: glyph_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sample     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = '0;
                if (one_cold) state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (!one_cold) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (changed) begin
                    cnt_next = '0;
                end else if (cnt_reg == CNT_LAST) begin
                    cnt_next   = CNT_SAT;
                    sample     = 1'b1;
                    state_next = ST_HOLD;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            ST_HOLD: begin
                if (!one_cold) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (changed) begin
                    state_next = ST_SETTLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_slot
            assign slot_wr[gi]             = sample && lit[gi] && glyph_ok;
            assign shadow_next[4*gi +: 4]  = slot_wr[gi] ? glyph_nib : shadow_reg[4*gi +: 4];
            assign shadow_dp_next[gi]      = slot_wr[gi] ? ~seg_sync_reg[7] : shadow_dp_reg[gi];
        end
    endgenerate

    // A sample landing in the completion cycle starts the next scan
    always_comb begin
        seen_next = (complete ? '0 : seen_reg) | (sample ? lit : '0);
        bad_next  = (complete ? 1'b0 : bad_reg) | (sample && !glyph_ok);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            seg_meta_reg   <= '1;
            seg_sync_reg   <= '1;
            seg_prev_reg   <= '1;
            an_meta_reg    <= '1;
            an_sync_reg    <= '1;
            an_prev_reg    <= '1;
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            seen_reg       <= '0;
            bad_reg        <= 1'b0;
            shadow_reg     <= '0;
            shadow_dp_reg  <= '0;
            word_reg       <= '0;
            dp_reg         <= '0;
            word_valid_reg <= 1'b0;
            pat_err_reg    <= 1'b0;
        end else begin
            seg_meta_reg   <= seg_in;
            seg_sync_reg   <= seg_meta_reg;
            seg_prev_reg   <= seg_sync_reg;
            an_meta_reg    <= an_in;
            an_sync_reg    <= an_meta_reg;
            an_prev_reg    <= an_sync_reg;
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            seen_reg       <= seen_next;
            bad_reg        <= bad_next;
            shadow_reg     <= shadow_next;
            shadow_dp_reg  <= shadow_dp_next;
            word_valid_reg <= complete && !bad_reg;
            pat_err_reg    <= complete && bad_reg;
            if (complete && !bad_reg) begin
                word_reg <= shadow_reg;
                dp_reg   <= shadow_dp_reg;
            end
        end
    end

    assign word_out   = word_reg;
    assign dp_out     = dp_reg;
    assign word_valid = word_valid_reg;
    assign pat_err    = pat_err_reg;
endmodule

// File: tb/tb_seg7_scan_reader.sv
// Bench for seg7_scan_reader: directed scenarios plus a randomized run-based scan
// model that predicts which pin windows get sampled and which scans publish.
module tb_seg7_scan_reader;
    localparam int NDIG   = 4;
    localparam int SETTLE = 4;
    localparam logic [3:0] IDLE_AN  = 4'b1111;
    localparam logic [7:0] IDLE_SEG = 8'hFF;
    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct packed {
        logic        good;
        logic [15:0] word;
        logic [3:0]  dp;
    } ev_t;

    logic        clock = 1'b0;
    logic        resetn;
    logic [7:0]  seg_in;
    logic [3:0]  an_in;
    logic [15:0] word_out;
    logic [3:0]  dp_out;
    logic        word_valid;
    logic        pat_err;

    int n_checks = 0;
    int n_fail   = 0;
    int both_cnt = 0;
    ev_t obs_q[$];
    ev_t exp_q[$];

    // Pin-run tracker and scan model
    logic [3:0]  cur_an;
    logic [7:0]  cur_seg;
    int          cur_len;
    logic [3:0]  m_seen;
    logic        m_bad;
    logic [3:0]  m_nib [4];
    logic [3:0]  m_dp;
    logic [15:0] m_word;
    logic [3:0]  m_dpw;

    always #5 clock = ~clock;

    seg7_scan_reader #(.NDIG(NDIG), .SETTLE(SETTLE)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .seg_in     (seg_in),
        .an_in      (an_in),
        .word_out   (word_out),
        .dp_out     (dp_out),
        .word_valid (word_valid),
        .pat_err    (pat_err)
    );

    always @(negedge clock) begin
        if (word_valid) begin
            obs_q.push_back('{good: 1'b1, word: word_out, dp: dp_out});
            $display("[%0t] word_valid word=%h dp=%b", $time, word_out, dp_out);
        end
        if (pat_err) begin
            obs_q.push_back('{good: 1'b0, word: word_out, dp: dp_out});
            $display("[%0t] pat_err word=%h dp=%b", $time, word_out, dp_out);
        end
        if (word_valid && pat_err) both_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        m_seen = '0;
        m_bad  = 1'b0;
        for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
        m_dp   = '0;
        m_word = '0;
        m_dpw  = '0;
        exp_q.delete();
    endtask

    task automatic model_sample(input logic [3:0] an, input logic [7:0] seg);
        int d;
        int idx;
        d   = 0;
        idx = -1;
        for (int i = 0; i < 4; i++) if (!an[i]) d = i;
        for (int k = 0; k < 16; k++) if (GLYPH[k] == seg[6:0]) idx = k;
        if (idx >= 0) begin
            m_nib[d] = idx[3:0];
            m_dp[d]  = ~seg[7];
        end else begin
            m_bad = 1'b1;
        end
        m_seen[d] = 1'b1;
        if (m_seen == 4'b1111) begin
            if (!m_bad) begin
                for (int i = 0; i < 4; i++) m_word[4*i +: 4] = m_nib[i];
                m_dpw = m_dp;
            end
            exp_q.push_back('{good: !m_bad, word: m_word, dp: m_dpw});
            m_seen = '0;
            m_bad  = 1'b0;
        end
    endtask

    // A run of identical one-cold pins lasting SETTLE+1 cycles or more is sampled once
    task automatic finalize_run();
        if ($countones(~cur_an) == 1 && cur_len >= SETTLE + 1) model_sample(cur_an, cur_seg);
    endtask

    task automatic put(input logic [3:0] an, input logic [7:0] seg, input int n);
        if (an == cur_an && seg == cur_seg) begin
            cur_len += n;
        end else begin
            finalize_run();
            cur_an  = an;
            cur_seg = seg;
            cur_len = n;
        end
        an_in  = an;
        seg_in = seg;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        finalize_run();
        resetn = 1'b0;
        an_in  = IDLE_AN;
        seg_in = IDLE_SEG;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
        resetn  = 1'b1;
        model_clear();
        cur_an  = IDLE_AN;
        cur_seg = IDLE_SEG;
        cur_len = 0;
    endtask

    task automatic test_reset();
        do_reset(2);
        n_checks++; if (word_out !== 16'h0) begin n_fail++; $display("FAIL reset_word: got %h want 0000", word_out); end
        n_checks++; if (dp_out !== 4'h0) begin n_fail++; $display("FAIL reset_dp: got %b want 0000", dp_out); end
        n_checks++; if (word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", word_valid); end
        n_checks++; if (pat_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", pat_err); end
        obs_q.delete();
        put(IDLE_AN, IDLE_SEG, 6);
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL reset_idle_pulses: got %0d want 0", obs_q.size()); end
    endtask

    task automatic test_good_scan();
        int ng, nb;
        obs_q.delete();
        put(4'b1110, 8'hF9, 8);
        put(4'b1101, 8'hA4, 8);
        put(4'b1011, 8'hB0, 8);
        put(4'b0111, 8'h19, 8);
        put(IDLE_AN, IDLE_SEG, 10);
        ng = 0; nb = 0;
        foreach (obs_q[i]) if (obs_q[i].good) ng++; else nb++;
        n_checks++; if (ng != 1) begin n_fail++; $display("FAIL good_valid_count: got %0d want 1", ng); end
        n_checks++; if (nb != 0) begin n_fail++; $display("FAIL good_err_count: got %0d want 0", nb); end
        n_checks++; if (word_out !== 16'h4321) begin n_fail++; $display("FAIL good_word: got %h want 4321", word_out); end
        n_checks++; if (dp_out !== 4'b1000) begin n_fail++; $display("FAIL good_dp: got %b want 1000", dp_out); end
        if (obs_q.size() > 0) begin
            n_checks++;
            if (obs_q[0].word !== 16'h4321) begin n_fail++; $display("FAIL good_pulse_word: got %h want 4321", obs_q[0].word); end
        end
    endtask

    task automatic test_bad_glyph();
        int ng, nb;
        obs_q.delete();
        put(4'b1110, 8'hF9, 8);
        put(4'b1101, 8'hA4, 8);
        put(4'b1011, 8'hFF, 8);
        put(4'b0111, 8'h19, 8);
        put(IDLE_AN, IDLE_SEG, 10);
        ng = 0; nb = 0;
        foreach (obs_q[i]) if (obs_q[i].good) ng++; else nb++;
        n_checks++; if (nb != 1) begin n_fail++; $display("FAIL bad_err_count: got %0d want 1", nb); end
        n_checks++; if (ng != 0) begin n_fail++; $display("FAIL bad_valid_count: got %0d want 0", ng); end
        n_checks++; if (word_out !== 16'h4321) begin n_fail++; $display("FAIL bad_word_hold: got %h want 4321", word_out); end
        n_checks++; if (dp_out !== 4'b1000) begin n_fail++; $display("FAIL bad_dp_hold: got %b want 1000", dp_out); end
    endtask

    task automatic test_short_window();
        int ng;
        obs_q.delete();
        put(4'b1110, 8'hF9, 8);
        for (int i = 0; i < SETTLE + 1; i++) put(4'b1101, (i % 2 == 0) ? 8'hA4 : 8'hF9, 1);
        put(4'b1011, 8'hB0, 8);
        put(4'b0111, 8'h19, 8);
        put(IDLE_AN, IDLE_SEG, 10);
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL short_no_pulse: got %0d want 0", obs_q.size()); end
        put(4'b1101, 8'hC0, 8);
        put(IDLE_AN, IDLE_SEG, 10);
        ng = 0;
        foreach (obs_q[i]) if (obs_q[i].good) ng++;
        n_checks++; if (ng != 1 || obs_q.size() != 1) begin n_fail++; $display("FAIL short_complete: got %0d events want 1 valid", obs_q.size()); end
        n_checks++; if (word_out !== 16'h4301) begin n_fail++; $display("FAIL short_word: got %h want 4301", word_out); end
    endtask

    task automatic test_illegal_select();
        obs_q.delete();
        put(4'b1110, 8'h12, 8);
        put(4'b1100, 8'h99, 20);
        put(4'b1111, 8'hF9, 20);
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL illegal_no_pulse: got %0d want 0", obs_q.size()); end
        put(4'b1101, 8'h82, 8);
        put(4'b1011, 8'hF8, 8);
        put(4'b0111, 8'h80, 8);
        put(IDLE_AN, IDLE_SEG, 10);
        n_checks++; if (obs_q.size() != 1) begin n_fail++; $display("FAIL illegal_pulse_count: got %0d want 1", obs_q.size()); end
        n_checks++; if (word_out !== 16'h8765) begin n_fail++; $display("FAIL illegal_word: got %h want 8765", word_out); end
        n_checks++; if (dp_out !== 4'b0001) begin n_fail++; $display("FAIL illegal_dp: got %b want 0001", dp_out); end
    endtask

    task automatic test_reset_mid();
        int ng;
        obs_q.delete();
        put(4'b1110, 8'h88, 8);
        put(4'b1101, 8'h83, 8);
        put(IDLE_AN, IDLE_SEG, 10);
        do_reset(1);
        put(4'b1011, 8'hC6, 8);
        put(4'b0111, 8'h21, 8);
        put(IDLE_AN, IDLE_SEG, 10);
        n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rstmid_no_pulse: got %0d want 0", obs_q.size()); end
        n_checks++; if (word_out !== 16'h0) begin n_fail++; $display("FAIL rstmid_word_zero: got %h want 0000", word_out); end
        put(4'b1110, 8'h88, 8);
        put(4'b1101, 8'h83, 8);
        put(4'b1011, 8'hC6, 8);
        put(4'b0111, 8'h21, 8);
        put(IDLE_AN, IDLE_SEG, 10);
        ng = 0;
        foreach (obs_q[i]) if (obs_q[i].good) ng++;
        n_checks++; if (ng != 1 || obs_q.size() != 1) begin n_fail++; $display("FAIL rstmid_full_scan: got %0d events want 1 valid", obs_q.size()); end
        n_checks++; if (word_out !== 16'hDCBA) begin n_fail++; $display("FAIL rstmid_word: got %h want dcba", word_out); end
        n_checks++; if (dp_out !== 4'b1000) begin n_fail++; $display("FAIL rstmid_dp: got %b want 1000", dp_out); end
    endtask

    task automatic test_back_to_back();
        int kind, d, len, g, rr;
        logic [3:0] an;
        logic [7:0] seg;
        do_reset(2);
        obs_q.delete();
        both_cnt = 0;
        rr = 0;
        for (int r = 0; r < 90; r++) begin
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                an = 4'($urandom_range(0, 15));
                if ($countones(~an) == 1) an = 4'b1100;
                seg = 8'($urandom);
                len = $urandom_range(1, 8);
            end else if (kind <= 2) begin
                d   = $urandom_range(0, 3);
                an  = ~(4'b0001 << d);
                seg = 8'($urandom);
                len = $urandom_range(1, SETTLE);
            end else begin
                d = rr % 4;
                rr++;
                if ($urandom_range(0, 4) == 0) d = $urandom_range(0, 3);
                an = ~(4'b0001 << d);
                if ($urandom_range(0, 7) == 0) begin
                    seg = 8'($urandom);
                end else begin
                    g   = $urandom_range(0, 15);
                    seg = {1'($urandom_range(0, 1)), GLYPH[g]};
                end
                len = $urandom_range(SETTLE + 1, 10);
            end
            put(an, seg, len);
        end
        put(IDLE_AN, IDLE_SEG, 12);
        n_checks++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_event_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_event_%0d: got good=%b word=%h dp=%b want good=%b word=%h dp=%b", i,
                         obs_q[i].good, obs_q[i].word, obs_q[i].dp, exp_q[i].good, exp_q[i].word, exp_q[i].dp);
            end
        end
        n_checks++; if (word_out !== m_word) begin n_fail++; $display("FAIL rand_final_word: got %h want %h", word_out, m_word); end
        n_checks++; if (dp_out !== m_dpw) begin n_fail++; $display("FAIL rand_final_dp: got %b want %b", dp_out, m_dpw); end
        n_checks++; if (both_cnt != 0) begin n_fail++; $display("FAIL rand_both_pulses: got %0d want 0", both_cnt); end
    endtask

    initial begin
        resetn  = 1'b0;
        an_in   = IDLE_AN;
        seg_in  = IDLE_SEG;
        cur_an  = IDLE_AN;
        cur_seg = IDLE_SEG;
        cur_len = 0;
        model_clear();
        @(posedge clock);
        #1;
        test_reset();
        test_good_scan();
        test_bad_glyph();
        test_short_window();
        test_illegal_select();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
